sd_pio_clkgen: RTL
==================

# sd_pio_clkgen

Parametrised Avalon-MM PIO output port with a hardware clock-burst generator on one selected bit. It replaces single-bit bit-banged SD-card strobes (SD_CLK and friends) in the system_0 peripheral set. Software can drive all bits directly, set or clear bits atomically, or have the block emit exactly N clock pulses at a programmable rate with busy/done status. It sits on the system interconnect as a zero-wait-state slave.

## Interface
- WIDTH, 1: number of output bits, 1..32.
- RESET_VALUE, 0: value of out_port after reset; bit CLK_BIT is forced to 0 regardless.
- CLK_BIT, 0: index of the bit owned by the burst generator, less than WIDTH.
- DIV_WIDTH, 16: width of the divider register.
- CNT_WIDTH, 16: width of the burst counter.
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; upper bits are ignored where a register is narrower.
- readdata  out  32  combinational read data, zero-extended; unmapped addresses return 0.
- out_port  out  WIDTH  registered output pins.

## Operation
- A write occurs on a cycle where chipselect=1 and write_n=0.
- Register map:
  - 0 DATA, read/write: write loads out_port; read returns out_port.
  - 1 OUTSET, write-only: bits written as 1 are set.
  - 2 OUTCLR, write-only: bits written as 1 are cleared.
  - 3 DIVIDER, read/write: half-period minus 1, in clk cycles.
  - 4 BURST, read/write: writing N starts N pulses; read returns the remaining count.
  - 5 STATUS: bit0 busy (read-only); bit1 done (sticky, write 1 to clear); bit2 abort (write-only, reads 0).
- Reset values:
  - out_port = RESET_VALUE with bit CLK_BIT = 0.
  - DIVIDER = 0, remaining = 0, busy = 0, done = 0.
- Generator FSM states: IDLE, RUN_LO, RUN_HI.
- IDLE, on a BURST write with N≠0:
  - go to RUN_LO, drive CLK_BIT low, load phase counter with DIVIDER, set remaining = N, clear done.
- IDLE, on a BURST write with N=0:
  - stay IDLE and set done.
- RUN_LO and RUN_HI:
  - If phase counter ≠ 0, decrement it.
  - If phase counter = 0, reload it with DIVIDER and switch phase. RUN_LO→RUN_HI drives CLK_BIT high.
  - RUN_HI→RUN_LO drives CLK_BIT low and decrements remaining.
  - If remaining was 1, go to IDLE instead, with CLK_BIT = 0 and done set.
- busy = (state ≠ IDLE).
- A DIVIDER write while busy takes effect at the next reload.
- A BURST write while busy is ignored.
- An abort write (STATUS bit2 = 1) in any state:
  - go to IDLE, drive CLK_BIT low, set remaining = 0; done stays unchanged.
- Writes to DATA, OUTSET or OUTCLR while busy update every bit except CLK_BIT, which is owned by the generator. In IDLE they update all bits, including CLK_BIT.
- If the same STATUS write sets done-clear and completion occurs in that cycle, completion wins and done = 1.

## Timing
- All register updates take effect on the clk edge that samples the write, with no wait states.
- readdata is combinational from address and the current register state, so it is valid in the same cycle.
- The first cycle with busy=1 is the cycle after the BURST write.
- Each phase lasts DIVIDER+1 cycles, so one pulse is 2·(DIVIDER+1) cycles.
- A burst is busy for exactly 2·N·(DIVIDER+1) cycles, then busy=0 and done=1 on the same edge.
- An asynchronous reset asserted mid-burst returns every register to its reset value immediately. No partial pulse is required after reset releases.

## Configuration
- SD_PIO_CLKGEN_IRQ_EN:
  - Defined: adds output port irq (1 bit, registered, reset 0) and STATUS bit3 irq_en (read/write, reset 0). irq = done & irq_en.
  - Undefined: the irq port does not exist and STATUS bit3 reads 0 and ignores writes.

## Test plan
- Reset with WIDTH=4, RESET_VALUE=4'hF, CLK_BIT=0 -> out_port=4'hE; DIVIDER, BURST and STATUS read 0.
- DATA write 4'h5, OUTSET 4'h2, OUTCLR 4'h4 -> out_port 4'h5, then 4'h7, then 4'h3, each on the cycle after its write.
- DIVIDER=1, BURST=3:
  - CLK_BIT pattern is 0,0,1,1 repeated 3 times over 12 cycles.
  - busy is high for exactly 12 cycles.
  - BURST reads 3, 2, 1 in turn, then 0; done=1 after completion.
- During a burst with DIVIDER=0 and N=8:
  - DATA write 4'hF -> bits 3:1 become 1 and CLK_BIT keeps toggling.
  - BURST write 2 is ignored; 16 busy cycles total.
- Abort written in the 5th cycle of a DIVIDER=3, N=4 burst -> next cycle: busy=0, CLK_BIT=0, remaining=0, done=0.
- With SD_PIO_CLKGEN_IRQ_EN and irq_en=1:
  - A BURST=0 write raises irq on the next cycle.
  - A STATUS write of 0x2 drops irq on the following cycle.

Source files
------------

// File: rtl/sd_pio_clkgen.sv
// Avalon-MM PIO output port with a hardware clock-burst generator on bit CLK_BIT.
// Optional feature: define SD_PIO_CLKGEN_IRQ_EN to add the irq output and STATUS.irq_en.
module sd_pio_clkgen #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CLK_BIT     = 0,
   parameter int               DIV_WIDTH   = 16,
   parameter int               CNT_WIDTH   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
`ifdef SD_PIO_CLKGEN_IRQ_EN
   output logic [WIDTH-1:0] out_port,
   output logic             irq
`else
   output logic [WIDTH-1:0] out_port
`endif
);

   typedef enum logic [1:0] {IDLE, RUN_LO, RUN_HI} state_t;

   localparam logic [2:0] A_DATA    = 3'd0;
   localparam logic [2:0] A_OUTSET  = 3'd1;
   localparam logic [2:0] A_OUTCLR  = 3'd2;
   localparam logic [2:0] A_DIVIDER = 3'd3;
   localparam logic [2:0] A_BURST   = 3'd4;
   localparam logic [2:0] A_STATUS  = 3'd5;

   localparam logic [WIDTH-1:0] RST_OUT = RESET_VALUE & ~(WIDTH'(1) << CLK_BIT);

   state_t                 state, state_n;
   logic [WIDTH-1:0]       out_q, out_n;
   logic [DIV_WIDTH-1:0]   divider, divider_n;
   logic [DIV_WIDTH-1:0]   phase, phase_n;
   logic [CNT_WIDTH-1:0]   remaining, remaining_n;
   logic                   done, done_n;
   logic                   wr;
   logic                   busy;
   logic                   irq_en_rd;

   assign wr       = chipselect & ~write_n;
   assign busy     = (state != IDLE);
   assign out_port = out_q;

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_n     = state;
      out_n       = out_q;
      divider_n   = divider;
      phase_n     = phase;
      remaining_n = remaining;
      done_n      = done;

      if (wr) begin
         case (address)
            A_DATA:    out_n     = writedata[WIDTH-1:0];
            A_OUTSET:  out_n     = out_q | writedata[WIDTH-1:0];
            A_OUTCLR:  out_n     = out_q & ~writedata[WIDTH-1:0];
            A_DIVIDER: divider_n = writedata[DIV_WIDTH-1:0];
            A_STATUS:  if (writedata[1]) done_n = 1'b0;
            default:   ;
         endcase
      end

      // While a burst runs the generator owns CLK_BIT; software writes cannot touch it.
      if (busy) out_n[CLK_BIT] = out_q[CLK_BIT];

      case (state)
         IDLE: begin
            if (wr && address == A_BURST) begin
               if (writedata[CNT_WIDTH-1:0] != '0) begin
                  state_n        = RUN_LO;
                  out_n[CLK_BIT] = 1'b0;
                  phase_n        = divider;
                  remaining_n    = writedata[CNT_WIDTH-1:0];
                  done_n         = 1'b0;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         RUN_LO: begin
            if (phase != '0) begin
               phase_n = phase - DIV_WIDTH'(1);
            end else begin
               phase_n        = divider;
               state_n        = RUN_HI;
               out_n[CLK_BIT] = 1'b1;
            end
         end
         RUN_HI: begin
            if (phase != '0) begin
               phase_n = phase - DIV_WIDTH'(1);
            end else begin
               phase_n        = divider;
               out_n[CLK_BIT] = 1'b0;
               remaining_n    = remaining - CNT_WIDTH'(1);
               // Completion is applied after the done-clear above, so it wins a same-cycle race.
               if (remaining == CNT_WIDTH'(1)) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n = RUN_LO;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (wr && address == A_STATUS && writedata[2]) begin
         state_n        = IDLE;
         out_n[CLK_BIT] = 1'b0;
         remaining_n    = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_q     <= RST_OUT;
         divider   <= '0;
         phase     <= '0;
         remaining <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         out_q     <= out_n;
         divider   <= divider_n;
         phase     <= phase_n;
         remaining <= remaining_n;
         done      <= done_n;
      end
   end

`ifdef SD_PIO_CLKGEN_IRQ_EN
   logic irq_en, irq_en_n;

   always_comb begin
      irq_en_n = irq_en;
      if (wr && address == A_STATUS) irq_en_n = writedata[3];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         irq_en <= irq_en_n;
         irq    <= done_n & irq_en_n;
      end
   end

   assign irq_en_rd = irq_en;
`else
   assign irq_en_rd = 1'b0;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         A_DATA:    readdata = 32'(out_q);
         A_DIVIDER: readdata = 32'(divider);
         A_BURST:   readdata = 32'(remaining);
         A_STATUS:  readdata = {28'd0, irq_en_rd, 1'b0, done, busy};
         default:   readdata = '0;
      endcase
   end

   // Upper writedata bits beyond the narrowest register are intentionally ignored.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

endmodule
